// File: rtl/cim_gemm_engine.sv
// rtl/cim_gemm_engine.sv - bit-serial compute-in-memory GEMV engine with quantised readout
// Optional macro CIM_ADC_SATURATE_EN: clamp the quantised value instead of wrapping it.
module cim_gemm_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int ROWS          = 128,
    parameter int IN_PAR        = 8,
    parameter int IN_PREC       = 4,
    parameter int OUT_PAR       = 8,
    parameter int ADC_PRECISION = 6,
    parameter int ADC_SHIFT     = 8,
    parameter int ACC_WIDTH     = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [$clog2(OUT_PAR*ROWS)-1:0]     wr_addr,
    input  logic [4*DATA_WIDTH-1:0]             wr_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [$clog2(ROWS)-1:0]             in_addr,
    input  logic [IN_PAR*IN_PREC-1:0]           in_data,
    input  logic                                accumulate,
    output logic                                busy,
    output logic                                done,
    input  logic [$clog2(OUT_PAR)-1:0]          out_sel,
    output logic [31:0]                         out_data
);

    localparam int AW = $clog2(OUT_PAR*ROWS);
    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(OUT_PAR);
    localparam int CW = $clog2(IN_PREC);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t                        state;
    logic [CW-1:0]                 bit_cnt;
    logic [IN_PREC-1:0]            in_lat [IN_PAR];
    logic [RW-1:0]                 addr_lat;
    logic                          acc_lat;
    logic                          accept;

    logic [DATA_WIDTH-1:0]         mem  [OUT_PAR][ROWS];
    logic signed [ACC_WIDTH-1:0]   acc  [OUT_PAR];
    logic signed [ACC_WIDTH-1:0]   step [OUT_PAR];

    logic [SW-1:0]                 wr_bank;
    logic [RW-1:0]                 wr_row;

    assign in_ready = (state == IDLE) && !wr_en;
    assign accept   = in_valid && in_ready;

    assign wr_bank = wr_addr[AW-1:RW];
    assign wr_row  = {wr_addr[RW-1:2], 2'b00};

    // Weight store has no reset so that an aborted operation keeps the loaded model.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            for (int j = 0; j < 4; j++) begin
                mem[wr_bank][wr_row | RW'(j)] <= wr_data[(3-j)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // One input bit-plane per cycle: sum the weights whose input bit is set, then weight by 2^k.
    always_comb begin
        for (int c = 0; c < OUT_PAR; c++) begin
            step[c] = '0;
            for (int i = 0; i < IN_PAR; i++) begin
                if (in_lat[i][bit_cnt]) begin
                    step[c] = step[c] + ACC_WIDTH'($signed(mem[c][addr_lat + RW'(i)]));
                end
            end
            step[c] = step[c] << bit_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_cnt  <= '0;
            addr_lat <= '0;
            acc_lat  <= 1'b0;
            for (int i = 0; i < IN_PAR; i++) begin
                in_lat[i] <= '0;
            end
            for (int c = 0; c < OUT_PAR; c++) begin
                acc[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        for (int i = 0; i < IN_PAR; i++) begin
                            in_lat[i] <= in_data[(IN_PAR-1-i)*IN_PREC +: IN_PREC];
                        end
                        addr_lat <= in_addr;
                        acc_lat  <= accumulate;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int c = 0; c < OUT_PAR; c++) begin
                        if (bit_cnt == '0 && !acc_lat) begin
                            acc[c] <= step[c];
                        end else begin
                            acc[c] <= acc[c] + step[c];
                        end
                    end
                    if (bit_cnt == CW'(IN_PREC-1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    localparam logic signed [ACC_WIDTH-1:0] QMAX = ACC_WIDTH'((1 << (ADC_PRECISION-1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] QMIN = -ACC_WIDTH'(1 << (ADC_PRECISION-1));

    logic signed [ACC_WIDTH-1:0] acc_sel;
    logic signed [ACC_WIDTH-1:0] q_full;
    logic signed [ACC_WIDTH-1:0] q_lim;
    logic                        unused_bits;

    always_comb begin
        acc_sel = '0;
        if (int'(out_sel) < OUT_PAR) begin
            acc_sel = acc[out_sel];
        end
        q_full = acc_sel >>> ADC_SHIFT;
`ifdef CIM_ADC_SATURATE_EN
        if (q_full > QMAX) begin
            q_lim = QMAX;
        end else if (q_full < QMIN) begin
            q_lim = QMIN;
        end else begin
            q_lim = q_full;
        end
`else
        q_lim = q_full;
`endif
        out_data = {{(32-ADC_PRECISION){q_lim[ADC_PRECISION-1]}}, q_lim[ADC_PRECISION-1:0]};
    end

    assign unused_bits = ^{wr_addr[1:0], q_lim, QMAX, QMIN};

endmodule

// File: tb/tb_cim_gemm_engine.sv
// tb/tb_cim_gemm_engine.sv - scoreboard bench for cim_gemm_engine with directed vectors
module tb_cim_gemm_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_addr;
    logic [31:0] in_data;
    logic        accumulate;
    logic        busy;
    logic        done;
    logic [2:0]  out_sel;
    logic [31:0] out_data;

    cim_gemm_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .accumulate (accumulate),
        .busy       (busy),
        .done       (done),
        .out_sel    (out_sel),
        .out_data   (out_data)
    );

    always #10 clk = ~clk;

    typedef struct {
        int          op;
        int          sel;
        logic [31:0] val;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   op_id  = 0;

`ifdef CIM_ADC_SATURATE_EN
    localparam logic [31:0] EXP_S3 = 32'd31;
`else
    localparam logic [31:0] EXP_S3 = 32'hFFFF_FFFB;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic expect_out(input int sel, input logic [31:0] val, input bit last);
        exp_t e;
        e.op   = op_id;
        e.sel  = sel;
        e.val  = val;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Monitor: on each done pulse, sweep the channels queued for that operation.
    initial begin : monitor
        exp_t e;
        bit   fin;
        out_sel = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got done=1 want no pulse");
                end else begin
                    fin = 1'b0;
                    while (!fin && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        out_sel = e.sel[2:0];
                        #1;
                        check($sformatf("op%0d_sel%0d", e.op, e.sel), out_data, e.val);
                        fin = e.last;
                    end
                    out_sel = '0;
                end
            end
        end
    end

    task automatic do_write(input logic [9:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || done) && n < 30);
        if (n >= 30) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [6:0] addr, input logic [31:0] data, input logic acc);
        int n = 0;
        @(negedge clk);
        in_addr    = addr;
        in_data    = data;
        accumulate = acc;
        in_valid   = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        in_valid   = 1'b0;
        in_addr    = '0;
        in_data    = '0;
        accumulate = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", out_data, 32'd0);
        rst_n = 1'b1;

        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 10'(7*128 + 64);
        wr_data = '0;
        #1 check("ready_during_wr", 32'(in_ready), 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        #1 check("ready_after_wr", 32'(in_ready), 32'd1);

        for (int b = 0; b < 8; b++) begin
            do_write(10'(b*128 + 0), 32'h0);
            do_write(10'(b*128 + 4), 32'h0);
            do_write(10'(b*128 + 124), 32'h0);
        end
        do_write(10'd0, 32'h1010_1010);
        do_write(10'd4, 32'h1010_1010);

        // Scenario 1 and 2
        op_id++;
        expect_out(0, 32'd7, 0);
        for (int c = 1; c < 8; c++) expect_out(c, 32'd0, c == 7);
        run_op(7'd0, 32'hFFFF_FFFF, 1'b0);
        op_id++;
        expect_out(0, 32'd15, 1);
        run_op(7'd0, 32'hFFFF_FFFF, 1'b1);
        op_id++;
        expect_out(0, 32'd7, 1);
        run_op(7'd0, 32'hFFFF_FFFF, 1'b0);

        // Scenario 3: quantisation window overflow
        do_write(10'd128, 32'h7F7F_7F7F);
        do_write(10'd132, 32'h7F7F_7F7F);
        op_id++;
        expect_out(0, 32'd7, 0);
        expect_out(1, EXP_S3, 1);
        run_op(7'd0, 32'hFFFF_FFFF, 1'b0);

        // Scenario 4: negative weights and row wrap
        do_write(10'd384, 32'h8080_8080);
        do_write(10'd388, 32'h8080_8080);
        op_id++;
        expect_out(0, 32'd0, 0);
        expect_out(1, 32'd3, 0);
        expect_out(3, 32'hFFFF_FFFC, 1);
        run_op(7'd0, 32'h1111_1111, 1'b0);
        do_write(10'd508, 32'h8000_0000);
        do_write(10'd384, 32'h0);
        op_id++;
        expect_out(0, 32'd0, 0);
        expect_out(1, 32'd1, 0);
        expect_out(3, 32'hFFFF_FFFF, 1);
        run_op(7'd124, 32'h1111_1111, 1'b0);
        op_id++;
        expect_out(1, 32'd0, 0);
        expect_out(3, 32'hFFFF_FFFF, 1);
        run_op(7'd124, 32'h1000_0000, 1'b0);

        // Scenario 5: done timing with in_valid held, write while busy ignored
        op_id++;
        expect_out(0, 32'd7, 1);
        @(negedge clk);
        in_addr    = 7'd0;
        in_data    = 32'hFFFF_FFFF;
        accumulate = 1'b0;
        in_valid   = 1'b1;
        #1 check("s5_ready_pre", 32'(in_ready), 32'd1);
        @(posedge clk);
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("s5_done_T%0d", n), 32'(done), (n == 4) ? 32'd1 : 32'd0);
            check($sformatf("s5_ready_T%0d", n), 32'(in_ready), (n == 5) ? 32'd1 : 32'd0);
            if (n == 2) begin
                wr_en   = 1'b1;
                wr_addr = 10'd0;
                wr_data = 32'h0;
            end
            if (n == 3) wr_en = 1'b0;
            if (n == 4) in_valid = 1'b0;
        end
        wait_idle();
        op_id++;
        expect_out(0, 32'd7, 1);
        run_op(7'd0, 32'hFFFF_FFFF, 1'b0);

        // Scenario 6: reset mid-compute aborts without done
        @(negedge clk);
        in_addr    = 7'd0;
        in_data    = 32'hFFFF_FFFF;
        accumulate = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("s6_busy_rst", 32'(busy), 32'd0);
        check("s6_out_rst", out_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("s6_no_done", 32'(seen), 32'd0);
        check("s6_acc_cleared", out_data, 32'd0);
        op_id++;
        expect_out(0, 32'd7, 1);
        run_op(7'd0, 32'hFFFF_FFFF, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cim_gemm_engine.md
CIM_GEMM_ENGINE -- requirements
Module: cim_gemm_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8: signed weight width.
REQ-002 Parameter ROWS, default 128: weights per output bank; power of two.
REQ-003 Parameter IN_PAR, default 8: input vector length per operation.
REQ-004 Parameter IN_PREC, default 4: unsigned input precision in bits.
REQ-005 Parameter OUT_PAR, default 8: output channels and weight banks; power of two.
REQ-006 Parameter ADC_PRECISION, default 6, and ADC_SHIFT, default 8: define the output quantisation window.
REQ-007 Parameter ACC_WIDTH, default 32: signed accumulator width.
REQ-008 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-009 clk  in  1  rising-edge clock.
REQ-010 rst_n  in  1  asynchronous active-low reset.
REQ-011 wr_en  in  1  weight write request.
REQ-012 wr_addr  in  log2(OUT_PAR*ROWS)  byte address, {bank, row}; low 2 bits ignored.
REQ-013 wr_data  in  4*DATA_WIDTH  four weights, MSB byte to the lowest address.
REQ-014 in_valid  in  1  compute request.
REQ-015 in_ready  out  1  compute request accepted when in_valid and in_ready are both high.
REQ-016 in_addr  in  log2(ROWS)  row base of the IN_PAR-weight window.
REQ-017 in_data  in  IN_PAR*IN_PREC  inputs; element 0 in the MSBs.
REQ-018 accumulate  in  1  1: add to the accumulators; 0: overwrite them.
REQ-019 busy  out  1  high while the state is not IDLE.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 out_sel  in  log2(OUT_PAR)  channel select.
REQ-022 out_data  out  32  quantised, sign-extended value of the selected channel.

Function
REQ-023 The FSM SHALL have the states IDLE, COMPUTE and DONE, with the transitions IDLE->COMPUTE on accept, COMPUTE->DONE after IN_PREC edges, and DONE->IDLE unconditionally.
REQ-024 in_ready SHALL equal (state==IDLE) && !wr_en; a write therefore takes priority over a compute request.
REQ-025 A write in IDLE SHALL store the four weights at the word-aligned address on the clock edge; wr_en outside IDLE SHALL be ignored.
REQ-026 On accept, the engine SHALL latch in_data, in_addr and accumulate, and clear the bit counter.
REQ-027 On the COMPUTE edge with bit index k (LSB first), each channel c SHALL add (sum over i of in_data[i][k] ? W[c][(in_addr+i) mod ROWS] : 0) << k to its accumulator.
REQ-028 Row addressing SHALL wrap modulo ROWS within a bank.
REQ-029 When the latched accumulate is 0, the k=0 step SHALL replace the accumulator rather than add to it.
REQ-030 Weights SHALL be signed two's complement, inputs unsigned, and accumulators signed ACC_WIDTH that wrap on overflow.
REQ-031 If the accept edge is T, done SHALL be high exactly in the cycle after edge T+IN_PREC, and in_ready SHALL be high again after edge T+IN_PREC+1.
REQ-032 Quantisation SHALL be q = acc >>> ADC_SHIFT (arithmetic shift), then reduced to ADC_PRECISION signed bits per REQ-038, then sign-extended to 32 bits.
REQ-033 out_data SHALL be combinational from out_sel and the accumulators, and SHALL be 0 when out_sel >= OUT_PAR.
REQ-034 During COMPUTE, out_data SHALL reflect the partially updated accumulators.

Reset
REQ-035 On rst_n low, the engine SHALL asynchronously set state=IDLE, done=0, busy=0, all accumulators=0 and the bit counter=0; in_ready SHALL be high after reset unless wr_en is high.
REQ-036 Weight memory SHALL NOT be affected by reset; it is zero at simulation start.
REQ-037 A reset during COMPUTE SHALL abort the operation and no done pulse SHALL occur.

Configuration
REQ-038 Macro CIM_ADC_SATURATE_EN: when defined, q SHALL clamp to [-2^(ADC_PRECISION-1), 2^(ADC_PRECISION-1)-1]; when undefined, q SHALL keep its low ADC_PRECISION bits (two's-complement wrap).

Verification
REQ-039 Scenario 1: weights 16 in bank 0, rows 0..7; in_data all 4'hF; accumulate=0; in_addr=0 -> acc0=1920, out_data(sel 0)=7, all other channels 0.
REQ-040 Scenario 2: repeat Scenario 1 with accumulate=1 -> acc0=3840, out_data=15; a third request with accumulate=0 -> out_data=7.
REQ-041 Scenario 3: weights 127, inputs all 4'hF -> acc=15240 (q=59); with CIM_ADC_SATURATE_EN out_data=31; without it out_data=0xFFFFFFFB (-5).
REQ-042 Scenario 4: weights 0x80 in bank 3, inputs all 1, out_sel=3 -> out_data=0xFFFFFFFC (-4); then in_addr=124 with row 124 holding 0x80 and rows 125..127 and 0..3 holding 0 -> out_data=0xFFFFFFFF (-1, exercises row wrap).
REQ-043 Scenario 5: in_valid held with an accept at edge T -> done high only after edge T+4; in_ready is 0 during wr_en; a write issued while busy leaves memory unchanged.
REQ-044 Scenario 6: rst_n pulsed low two cycles after accept -> done never asserts, accumulators read 0, weights persist.
